segment_port_arbiter: RTL and testbench

Shares the single read port and single write port of SegmentRegisterFile between NUM_REQ requesters, for example microcode, the interrupt/far-transfer loader and the debug port.
- Requests are arbitrated round-robin.
- Each request is sequenced as a write (2 cycles) or a read (3 cycles, covering the file's registered read).
- A one-cycle cs_changed pulse is raised whenever CS is written, so the prefetcher can flush.
- Sits directly between the requesters and SegmentRegisterFile.

---
 rtl/segment_port_arbiter_pkg.sv | 21 ++
 rtl/segment_port_arbiter_rr_arbiter.sv | 27 ++
 rtl/segment_port_arbiter.sv | 131 +++++++++++++
 tb/tb_segment_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_port_arbiter_pkg.sv
// Shared types and widths for the segment register file port arbiter.
package segment_port_arbiter_pkg;

  localparam int SEG_W     = 16;
  localparam int SEG_SEL_W = 2;

  typedef enum logic [SEG_SEL_W-1:0] {
    SEG_ES = 2'd0,
    SEG_CS = 2'd1,
    SEG_SS = 2'd2,
    SEG_DS = 2'd3
  } seg_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RDATA = 2'd3
  } state_e;

endpackage

// File: rtl/segment_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             valid_o
);

  int idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segment_port_arbiter.sv
// Round-robin sharing of the segment register file read/write ports between NUM_REQ requesters.
// Optional owner lock for atomic sequences is enabled with SEG_ARB_LOCK_EN.
module segment_port_arbiter
  import segment_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
`ifdef SEG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             lock,
  output logic                           locked,
`endif
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ*SEG_SEL_W-1:0]   sel,
  input  logic [NUM_REQ*SEG_W-1:0]       wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [SEG_W-1:0]               rdata,
  output logic                           busy,
  output logic                           cs_changed,
  output logic [SEG_SEL_W-1:0]           rf_rd_sel,
  input  logic [SEG_W-1:0]               rf_rd_val,
  output logic                           rf_wr_en,
  output logic [SEG_SEL_W-1:0]           rf_wr_sel,
  output logic [SEG_W-1:0]               rf_wr_val
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     rr_q;
  logic [SEG_SEL_W-1:0] sel_q;
  logic [SEG_W-1:0]     data_q;
  logic                 cs_chg_q;

  logic [NUM_REQ-1:0]   owner_oh;
  logic [NUM_REQ-1:0]   req_eff;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     rr_d;

  assign owner_oh = NUM_REQ'(1) << owner_q;

`ifdef SEG_ARB_LOCK_EN
  logic locked_q;
  logic hold_lock;

  // While the owner keeps its lock bit up, only that owner may win in IDLE.
  assign hold_lock = locked_q && (|(lock & owner_oh));
  assign req_eff   = hold_lock ? (req & owner_oh) : req;
  assign locked    = locked_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q <= 1'b0;
    end else if (((state_q == WRITE) || (state_q == READ)) && (|(lock & owner_oh))) begin
      locked_q <= 1'b1;
    end else if ((state_q == IDLE) && locked_q && !hold_lock) begin
      locked_q <= 1'b0;
    end
  end
`else
  assign req_eff = req;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_eff),
    .ptr_i   (rr_q),
    .gnt_o   (win_oh),
    .valid_o (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  assign rr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      sel_q    <= SEG_ES;
      data_q   <= '0;
      cs_chg_q <= 1'b0;
    end else begin
      cs_chg_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            owner_q <= win_idx;
            rr_q    <= rr_d;
            sel_q   <= sel[win_idx*SEG_SEL_W +: SEG_SEL_W];
            data_q  <= wdata[win_idx*SEG_W +: SEG_W];
            state_q <= we[win_idx] ? WRITE : READ;
          end
        end
        WRITE: begin
          // Flush request fires on every CS write, even if the value is unchanged.
          cs_chg_q <= (sel_q == SEG_CS);
          state_q  <= IDLE;
        end
        READ:    state_q <= RDATA;
        RDATA:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = ((state_q == WRITE) || (state_q == READ)) ? owner_oh : '0;
  assign rvalid     = (state_q == RDATA) ? owner_oh : '0;
  assign rdata      = (state_q == RDATA) ? rf_rd_val : '0;
  assign busy       = (state_q != IDLE);
  assign cs_changed = cs_chg_q;
  assign rf_rd_sel  = sel_q;
  assign rf_wr_en   = (state_q == WRITE);
  assign rf_wr_sel  = sel_q;
  assign rf_wr_val  = data_q;

endmodule

// File: tb/tb_segment_port_arbiter.sv
// Scoreboard bench for segment_port_arbiter with a behavioural segment register file.
module tb_segment_port_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   we = '0;
  logic [2*N-1:0] sel = '0;
  logic [16*N-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [15:0]    rdata;
  logic           busy;
  logic           cs_changed;
  logic [1:0]     rf_rd_sel;
  logic [15:0]    rf_rd_val = '0;
  logic           rf_wr_en;
  logic [1:0]     rf_wr_sel;
  logic [15:0]    rf_wr_val;
`ifdef SEG_ARB_LOCK_EN
  logic [N-1:0]   lock = '0;
  logic           locked;
`endif

  logic [15:0] regs [4] = '{default: 16'h0000};

  always #5 clk = ~clk;

  segment_port_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef SEG_ARB_LOCK_EN
    .lock       (lock),
    .locked     (locked),
`endif
    .req        (req),
    .we         (we),
    .sel        (sel),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .busy       (busy),
    .cs_changed (cs_changed),
    .rf_rd_sel  (rf_rd_sel),
    .rf_rd_val  (rf_rd_val),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_sel  (rf_wr_sel),
    .rf_wr_val  (rf_wr_val)
  );

  // Segment register file: write at the edge, registered read.
  always @(posedge clk) begin
    if (rf_wr_en) regs[rf_wr_sel] <= rf_wr_val;
    rf_rd_val <= regs[rf_rd_sel];
  end

  int checks = 0;
  int errors = 0;
  int cs_cnt = 0;

  typedef struct {
    int          who;
    bit          wr;
    logic [1:0]  s;
    logic [15:0] d;
  } g_t;

  typedef struct {
    int          who;
    logic [15:0] d;
  } r_t;

  g_t gq[$];
  r_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_g(input int who, input bit wr, input logic [1:0] s, input logic [15:0] d);
    g_t e;
    e.who = who; e.wr = wr; e.s = s; e.d = d;
    gq.push_back(e);
  endtask

  task automatic exp_r(input int who, input logic [15:0] d);
    r_t e;
    e.who = who; e.d = d;
    rq.push_back(e);
  endtask

  // Raise a request and hold it until its grant is seen; returns at that negedge.
  task automatic do_op(input int who, input bit w, input logic [1:0] s, input logic [15:0] d);
    int n;
    req[who] = 1'b1;
    we[who]  = w;
    sel[who*2 +: 2]    = s;
    wdata[who*16 +: 16] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[who] && n < 50);
    if (!gnt[who]) chk("gnt_timeout", 32'(gnt[who]), 32'd1);
    req[who] = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // Monitor
  g_t   mg;
  r_t   mr;
  bit   prev_cs = 1'b0;
  int   run = 0;
  int   exp_len = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_cs = 1'b0;
      run     = 0;
    end else begin
      chk("cs_changed_timing", 32'(cs_changed), 32'(prev_cs));
      if (cs_changed) cs_cnt++;
      prev_cs = rf_wr_en && (rf_wr_sel == 2'd1);

      if (gnt != '0) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          mg = gq.pop_front();
          exp_len = mg.wr ? 1 : 2;
          chk("gnt_owner", 32'(gnt), 32'(N'(1) << mg.who));
          chk("gnt_kind_wr_en", 32'(rf_wr_en), 32'(mg.wr));
          if (mg.wr) begin
            chk("wr_sel", 32'(rf_wr_sel), 32'(mg.s));
            chk("wr_val", 32'(rf_wr_val), 32'(mg.d));
          end else begin
            chk("rd_sel", 32'(rf_rd_sel), 32'(mg.s));
          end
        end
      end

      if (rvalid != '0) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", 32'(rvalid), 32'd0);
        end else begin
          mr = rq.pop_front();
          chk("rvalid_owner", 32'(rvalid), 32'(N'(1) << mr.who));
          chk("rdata", 32'(rdata), 32'(mr.d));
        end
      end

      if (busy) begin
        run++;
      end else if (run > 0) begin
        chk("busy_len", 32'(run), 32'(exp_len));
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_cs;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cs_changed", 32'(cs_changed), 32'd0);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_wr_sel", 32'(rf_wr_sel), 32'd0);
    chk("rst_wr_val", 32'(rf_wr_val), 32'd0);
    chk("rst_rd_sel", 32'(rf_rd_sel), 32'd0);
    reset_n = 1'b1;
    settle();

    // Single CS write
    exp_g(0, 1'b1, 2'd1, 16'h5678);
    do_op(0, 1'b1, 2'd1, 16'h5678);
    settle();
    chk("file_cs", 32'(regs[1]), 32'h5678);

    // Preload DS then read it back from requester 1
    exp_g(1, 1'b1, 2'd3, 16'hDEF0);
    do_op(1, 1'b1, 2'd3, 16'hDEF0);
    settle();
    exp_g(1, 1'b0, 2'd3, 16'h0);
    exp_r(1, 16'hDEF0);
    do_op(1, 1'b0, 2'd3, 16'h0);
    settle();

    // Requester 2 reads CS, leaving the pointer at 0
    exp_g(2, 1'b0, 2'd1, 16'h0);
    exp_r(2, 16'h5678);
    do_op(2, 1'b0, 2'd1, 16'h0);
    settle();

    // Three-way contention on ES
    exp_g(0, 1'b1, 2'd0, 16'h1111);
    exp_g(1, 1'b1, 2'd0, 16'h2222);
    exp_g(2, 1'b1, 2'd0, 16'h3333);
    fork
      do_op(0, 1'b1, 2'd0, 16'h1111);
      do_op(1, 1'b1, 2'd0, 16'h2222);
      do_op(2, 1'b1, 2'd0, 16'h3333);
    join
    settle();
    chk("file_es", 32'(regs[0]), 32'h3333);
    exp_g(0, 1'b0, 2'd0, 16'h0);
    exp_r(0, 16'h3333);
    do_op(0, 1'b0, 2'd0, 16'h0);
    settle();

    // Fairness: requester 0 streams, requester 2 joins after its first grant
    exp_g(0, 1'b1, 2'd2, 16'h0A0A);
    exp_g(2, 1'b1, 2'd2, 16'h2222);
    exp_g(0, 1'b1, 2'd2, 16'h0A0A);
    fork
      begin
        do_op(0, 1'b1, 2'd2, 16'h0A0A);
        do_op(0, 1'b1, 2'd2, 16'h0A0A);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!gnt[0] && n < 50);
        do_op(2, 1'b1, 2'd2, 16'h2222);
      end
    join
    settle();
    chk("file_ss", 32'(regs[2]), 32'h0A0A);
    exp_g(1, 1'b0, 2'd2, 16'h0);
    exp_r(1, 16'h0A0A);
    do_op(1, 1'b0, 2'd2, 16'h0);
    settle();

    // Reset during the WRITE cycle aborts the write
    exp_g(2, 1'b1, 2'd3, 16'hBAD0);
    do_op(2, 1'b1, 2'd3, 16'hBAD0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_wr_en", 32'(rf_wr_en), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_file_ds", 32'(regs[3]), 32'hDEF0);
    chk("post_rst_wr_val", 32'(rf_wr_val), 32'd0);
    chk("post_rst_rd_sel", 32'(rf_rd_sel), 32'd0);
    chk("post_rst_cs_changed", 32'(cs_changed), 32'd0);
    exp_g(0, 1'b0, 2'd3, 16'h0);
    exp_r(0, 16'hDEF0);
    do_op(0, 1'b0, 2'd3, 16'h0);
    settle();

`ifdef SEG_ARB_LOCK_EN
    // Locked CS write then read by requester 1 while requester 0 waits
    chk("lock_idle", 32'(locked), 32'd0);
    lock[1] = 1'b1;
    exp_g(1, 1'b1, 2'd1, 16'hAAAA);
    do_op(1, 1'b1, 2'd1, 16'hAAAA);
    exp_g(1, 1'b0, 2'd1, 16'h0);
    exp_r(1, 16'hAAAA);
    exp_g(0, 1'b0, 2'd0, 16'h0);
    exp_r(0, 16'h3333);
    fork
      begin
        do_op(1, 1'b0, 2'd1, 16'h0);
        repeat (5) @(negedge clk);
        chk("lock_held", 32'(locked), 32'd1);
        chk("lock_req0_waits", 32'(req[0] & ~gnt[0]), 32'd1);
        lock[1] = 1'b0;
      end
      do_op(0, 1'b0, 2'd0, 16'h0);
    join
    settle();
    chk("lock_released", 32'(locked), 32'd0);
    exp_cs = 2;
`else
    exp_cs = 1;
`endif

    chk("cs_pulse_count", 32'(cs_cnt), 32'(exp_cs));
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
